// File: rtl/rx_symbol_align.sv
// ---------------------------------------------------------------------------
// rx_symbol_align
//
// Receive-side 10-bit symbol aligner for an 8b/10b serial link. It hunts the
// serial bit stream for K28.5 commas (either disparity), establishes the
// symbol boundary, and then emits one boundary-aligned 10-bit symbol every
// ten bits. A small HUNT / CHECK / LOCKED state machine reports link lock.
//
// Parameters:
//   LOCK_CNT  consecutive aligned commas (first one included) to reach lock
//   LOSS_CNT  misaligned commas while locked, with no aligned comma between
//             them, that drop the link back to HUNT
//
// Ports:
//   CRC_CKL       in   recovered receive clock, rising-edge
//   RST_L         in   asynchronous active-low reset
//   data_in       in   serial bit, polarity corrected, bit a sent first
//   sym_out       out  [9:0] aligned symbol, bit a in [0], bit j in [9]
//   sym_valid     out  one-cycle strobe, sym_out holds a new symbol
//   sym_is_comma  out  qualifies sym_valid: symbol is K28.5
//   lock          out  high while LOCKED
//   align_err     out  one-cycle pulse, comma seen off the current boundary
// ---------------------------------------------------------------------------
module rx_symbol_align #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 4
) (
  input  logic       CRC_CKL,
  input  logic       RST_L,
  input  logic       data_in,
  output logic [9:0] sym_out,
  output logic       sym_valid,
  output logic       sym_is_comma,
  output logic       lock,
  output logic       align_err
);

  localparam int CCW = $clog2(LOCK_CNT + 1);
  localparam int MCW = $clog2(LOSS_CNT + 1);
  localparam logic [CCW-1:0] LOCK_MAX = CCW'(LOCK_CNT);
  localparam logic [MCW-1:0] LOSS_MAX = MCW'(LOSS_CNT);

  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t         state_q;
  logic [9:0]     sreg_q;
  logic [3:0]     fill_q;
  logic [3:0]     bitcnt_q;
  logic [CCW-1:0] comma_cnt_q;
  logic [MCW-1:0] mis_cnt_q;

  logic [9:0]     window;
  logic           fill_done;
  logic           match;
  logic           boundary;
  logic [CCW-1:0] comma_cnt_inc;
  logic [MCW-1:0] mis_cnt_inc;

  // The window already includes the bit being sampled this edge, so a symbol
  // is emitted on the same edge that delivers its last bit (bit j).
  assign window = {data_in, sreg_q[9:1]};

  // fill_q counts edges since reset; on the tenth edge the window holds ten
  // received bits, so reset zeros can never take part in a comma match.
  assign fill_done = (fill_q == 4'd9);
  assign match     = fill_done && ((window == K28_5_RDN) || (window == K28_5_RDP));
  assign boundary  = (bitcnt_q == 4'd9);

  // Saturating increments; counters never wrap.
  assign comma_cnt_inc = (comma_cnt_q == LOCK_MAX) ? comma_cnt_q : comma_cnt_q + CCW'(1);
  assign mis_cnt_inc   = (mis_cnt_q == LOSS_MAX) ? mis_cnt_q : mis_cnt_q + MCW'(1);

  always_ff @(posedge CRC_CKL or negedge RST_L) begin
    if (!RST_L) begin
      state_q      <= HUNT;
      sreg_q       <= 10'd0;
      fill_q       <= 4'd0;
      bitcnt_q     <= 4'd0;
      comma_cnt_q  <= '0;
      mis_cnt_q    <= '0;
      sym_out      <= 10'd0;
      sym_valid    <= 1'b0;
      sym_is_comma <= 1'b0;
      lock         <= 1'b0;
      align_err    <= 1'b0;
    end else begin
      sreg_q <= window;
      if (!fill_done) begin
        fill_q <= fill_q + 4'd1;
      end

      // Strobes default low; sym_out holds its last symbol.
      sym_valid    <= 1'b0;
      sym_is_comma <= 1'b0;
      align_err    <= 1'b0;
      bitcnt_q     <= boundary ? 4'd0 : bitcnt_q + 4'd1;

      case (state_q)
        HUNT: begin
          if (match) begin
            sym_out      <= window;
            sym_valid    <= 1'b1;
            sym_is_comma <= 1'b1;
            bitcnt_q     <= 4'd0;
            comma_cnt_q  <= CCW'(1);
            mis_cnt_q    <= '0;
            // A single-comma lock requirement is met by the first comma.
            state_q      <= (LOCK_CNT <= 1) ? LOCKED : CHECK;
            lock         <= (LOCK_CNT <= 1);
          end
        end

        CHECK: begin
          if (boundary) begin
            sym_out      <= window;
            sym_valid    <= 1'b1;
            sym_is_comma <= match;
            if (match) begin
              comma_cnt_q <= comma_cnt_inc;
              if (comma_cnt_inc == LOCK_MAX) begin
                state_q <= LOCKED;
                lock    <= 1'b1;
              end
            end
          end else if (match) begin
            // Comma off the tentative boundary: adopt the new boundary and
            // restart the aligned-comma count from this comma.
            align_err    <= 1'b1;
            sym_out      <= window;
            sym_valid    <= 1'b1;
            sym_is_comma <= 1'b1;
            bitcnt_q     <= 4'd0;
            comma_cnt_q  <= CCW'(1);
          end
        end

        LOCKED: begin
          if (boundary) begin
            sym_out      <= window;
            sym_valid    <= 1'b1;
            sym_is_comma <= match;
            if (match) begin
              mis_cnt_q <= '0;
            end
          end else if (match) begin
            // Once locked, a stray comma is only counted; the established
            // boundary is kept and nothing is emitted for it.
            align_err <= 1'b1;
            if (mis_cnt_inc == LOSS_MAX) begin
              state_q     <= HUNT;
              lock        <= 1'b0;
              comma_cnt_q <= '0;
              mis_cnt_q   <= '0;
              bitcnt_q    <= 4'd0;
            end else begin
              mis_cnt_q <= mis_cnt_inc;
            end
          end
        end

        default: begin
          state_q <= HUNT;
          lock    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_symbol_align.sv
// ---------------------------------------------------------------------------
// tb_rx_symbol_align
//
// Directed bench for rx_symbol_align. Each scenario pushes a bit stream into
// a queue, plays it one bit per clock (driven on the falling edge, sampled
// 1 time unit after the rising edge) and logs every emitted symbol, every
// align_err pulse and lock edges, indexed by the rising-edge count since the
// last reset release. Expected edge numbers and symbol values below were
// worked out by hand from the stream contents.
// ---------------------------------------------------------------------------
module tb_rx_symbol_align;

  logic       CRC_CKL = 1'b0;
  logic       RST_L   = 1'b0;
  logic       data_in = 1'b0;
  logic [9:0] sym_out;
  logic       sym_valid;
  logic       sym_is_comma;
  logic       lock;
  logic       align_err;

  always #5 CRC_CKL = ~CRC_CKL;

  rx_symbol_align #(
    .LOCK_CNT(3),
    .LOSS_CNT(4)
  ) dut (
    .CRC_CKL     (CRC_CKL),
    .RST_L       (RST_L),
    .data_in     (data_in),
    .sym_out     (sym_out),
    .sym_valid   (sym_valid),
    .sym_is_comma(sym_is_comma),
    .lock        (lock),
    .align_err   (align_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  bit   bits_q[$];
  int   v_edge[$];
  int   v_sym[$];
  int   v_comma[$];
  int   v_lock[$];
  int   ae_edge[$];
  int   edge_n;
  int   lock_rise;
  int   lock_fall;
  logic lock_prev;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Symbol bits go out LSB (bit a) first.
  task automatic push_sym(input logic [9:0] v);
    for (int i = 0; i < 10; i++) bits_q.push_back(v[i]);
  endtask

  // Raw bits in transmission order, written left to right.
  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) bits_q.push_back(s[i] == "1");
  endtask

  task automatic clear_log();
    v_edge.delete();
    v_sym.delete();
    v_comma.delete();
    v_lock.delete();
    ae_edge.delete();
    edge_n    = 0;
    lock_rise = -1;
    lock_fall = -1;
    lock_prev = 1'b0;
  endtask

  // Entered and left on a falling clock edge.
  task automatic run_bits();
    while (bits_q.size() > 0) begin
      data_in = bits_q.pop_front();
      @(posedge CRC_CKL);
      #1;
      edge_n++;
      if (sym_valid) begin
        v_edge.push_back(edge_n);
        v_sym.push_back(int'(sym_out));
        v_comma.push_back(int'(sym_is_comma));
        v_lock.push_back(int'(lock));
        $display("edge %0d: sym 0x%03h comma=%0b lock=%0b", edge_n, sym_out, sym_is_comma, lock);
      end
      if (align_err) begin
        ae_edge.push_back(edge_n);
        $display("edge %0d: align_err lock=%0b", edge_n, lock);
      end
      if (lock && !lock_prev) lock_rise = edge_n;
      if (!lock && lock_prev) lock_fall = edge_n;
      lock_prev = lock;
      @(negedge CRC_CKL);
    end
  endtask

  task automatic do_reset();
    RST_L   = 1'b0;
    data_in = 1'b0;
    repeat (3) @(negedge CRC_CKL);
    RST_L = 1'b1;
    clear_log();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_log();

    // Reset state, with clock edges occurring during reset.
    repeat (2) @(negedge CRC_CKL);
    check_val("rst_sym_out", int'(sym_out), 0);
    check_val("rst_sym_valid", int'(sym_valid), 0);
    check_val("rst_sym_is_comma", int'(sym_is_comma), 0);
    check_val("rst_lock", int'(lock), 0);
    check_val("rst_align_err", int'(align_err), 0);

    // 1: lock at zero offset.
    do_reset();
    repeat (3) push_sym(10'h17C);
    repeat (3) push_sym(10'h2AA);
    run_bits();
    check_val("s1_nvalid", v_edge.size(), 6);
    for (int i = 0; i < 6; i++) check_val($sformatf("s1_edge%0d", i), qget(v_edge, i), 10 * (i + 1));
    for (int i = 0; i < 6; i++) check_val($sformatf("s1_comma%0d", i), qget(v_comma, i), (i < 3) ? 1 : 0);
    check_val("s1_sym0", qget(v_sym, 0), 'h17C);
    check_val("s1_sym3", qget(v_sym, 3), 'h2AA);
    check_val("s1_lock_at_2nd", qget(v_lock, 1), 0);
    check_val("s1_lock_at_3rd", qget(v_lock, 2), 1);
    check_val("s1_lock_rise", lock_rise, 30);
    check_val("s1_naerr", ae_edge.size(), 0);

    // 2: arbitrary offset, 7 junk bits ahead of the stream.
    do_reset();
    push_str("1011001");
    repeat (3) push_sym(10'h17C);
    repeat (3) push_sym(10'h2AA);
    run_bits();
    check_val("s2_first_edge", qget(v_edge, 0), 17);
    check_val("s2_first_sym", qget(v_sym, 0), 'h17C);
    check_val("s2_first_comma", qget(v_comma, 0), 1);
    check_val("s2_nvalid", v_edge.size(), 6);
    check_val("s2_last_edge", qget(v_edge, 5), 67);
    check_val("s2_lock_rise", lock_rise, 37);

    // 3: RD+ and alternating disparity on one boundary.
    do_reset();
    push_sym(10'h283);
    push_sym(10'h17C);
    push_sym(10'h283);
    repeat (2) push_sym(10'h2AA);
    run_bits();
    check_val("s3_sym0", qget(v_sym, 0), 'h283);
    check_val("s3_sym1", qget(v_sym, 1), 'h17C);
    check_val("s3_sym2", qget(v_sym, 2), 'h283);
    for (int i = 0; i < 3; i++) check_val($sformatf("s3_comma%0d", i), qget(v_comma, i), 1);
    check_val("s3_lock_at_3rd", qget(v_lock, 2), 1);
    check_val("s3_lock_rise", lock_rise, 30);

    // 4: realign in CHECK after 2 aligned commas (comma shifted by 3 bits).
    do_reset();
    repeat (2) push_sym(10'h17C);
    push_str("101");
    repeat (3) push_sym(10'h17C);
    push_sym(10'h2AA);
    run_bits();
    check_val("s4_nvalid", v_edge.size(), 7);
    check_val("s4_old_bnd_edge", qget(v_edge, 2), 30);
    check_val("s4_old_bnd_sym", qget(v_sym, 2), 'h3E5);
    check_val("s4_old_bnd_comma", qget(v_comma, 2), 0);
    check_val("s4_realign_edge", qget(v_edge, 3), 33);
    check_val("s4_realign_comma", qget(v_comma, 3), 1);
    check_val("s4_naerr", ae_edge.size(), 1);
    check_val("s4_aerr_edge", qget(ae_edge, 0), 33);
    check_val("s4_new_bnd_edge", qget(v_edge, 4), 43);
    check_val("s4_lock_at_43", qget(v_lock, 4), 0);
    check_val("s4_lock_rise", lock_rise, 53);

    // 5: loss of lock after 4 misaligned commas.
    do_reset();
    repeat (3) push_sym(10'h17C);
    push_str("101");
    repeat (4) push_sym(10'h17C);
    repeat (2) push_sym(10'h2AA);
    run_bits();
    check_val("s5_lock_rise", lock_rise, 30);
    check_val("s5_naerr", ae_edge.size(), 4);
    for (int i = 0; i < 4; i++) check_val($sformatf("s5_aerr%0d", i), qget(ae_edge, i), 43 + 10 * i);
    check_val("s5_nvalid", v_edge.size(), 7);
    check_val("s5_last_valid", qget(v_edge, 6), 70);
    check_val("s5_sym_at_50", qget(v_sym, 4), 'h3E2);
    check_val("s5_lock_at_70", qget(v_lock, 6), 1);
    check_val("s5_lock_fall", lock_fall, 73);
    for (int i = 0; i < 4; i++) begin
      int hit;
      hit = 0;
      for (int k = 0; k < v_edge.size(); k++) if (v_edge[k] == 43 + 10 * i) hit = 1;
      check_val($sformatf("s5_novalid%0d", i), hit, 0);
    end

    // 6: reset while locked and mid-symbol, then re-acquire.
    do_reset();
    repeat (3) push_sym(10'h17C);
    push_str("01010");
    run_bits();
    check_val("s6_pre_lock", int'(lock), 1);
    check_val("s6_pre_sym", int'(sym_out), 'h17C);
    RST_L = 1'b0;
    #1;
    check_val("s6_rst_sym_out", int'(sym_out), 0);
    check_val("s6_rst_sym_valid", int'(sym_valid), 0);
    check_val("s6_rst_sym_is_comma", int'(sym_is_comma), 0);
    check_val("s6_rst_lock", int'(lock), 0);
    check_val("s6_rst_align_err", int'(align_err), 0);
    repeat (2) @(negedge CRC_CKL);
    RST_L = 1'b1;
    clear_log();
    // The first 8 bits together with two reset zeros would look like 10'h17C.
    push_str("11111010");
    repeat (3) push_sym(10'h17C);
    push_sym(10'h2AA);
    run_bits();
    check_val("s6_first_edge", qget(v_edge, 0), 18);
    check_val("s6_first_sym", qget(v_sym, 0), 'h17C);
    check_val("s6_nvalid", v_edge.size(), 4);
    check_val("s6_naerr", ae_edge.size(), 0);
    check_val("s6_lock_rise", lock_rise, 38);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
